// File: rtl/operand_bypass_pkg.sv
// Shared constants for the operand-forwarding selector: data/address width
// defaults, the hard-wired zero register and the hazard counter helpers.
package operand_bypass_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;
    localparam int HCNT_W     = 16;

    function automatic logic [HCNT_W-1:0] sat_inc(input logic [HCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/operand_bypass_wbuf.sv
// Small ring buffer of recently committed writebacks; the lookup returns the
// newest entry whose address matches.
module bypass_wbuf
    import operand_bypass_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              hit,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  ent_vld;
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [WIDTH-1:0]  ent_data [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld <= '0;
            wptr    <= '0;
        end else if (wr_en) begin
            ent_vld[wptr] <= 1'b1;
            wptr          <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
        end
    end

    // Payload carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_addr[wptr] <= wr_addr;
            ent_data[wptr] <= wr_data;
        end
    end

    // Walk oldest to newest so the last match (the newest) wins.
    always_comb begin
        hit     = 1'b0;
        rd_data = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = (DEPTH == 1) ? '0 : wptr + PW'(k);
            if (ent_vld[idx] && ent_addr[idx] == rd_addr) begin
                hit     = 1'b1;
                rd_data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/operand_bypass.sv
// Decode-stage operand selector: register file, in-flight forwarding sources or
// committed-write buffer, with load-use hazard detection and a registered output.
module operand_bypass
    import operand_bypass_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NSRC   = 3,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   req_valid,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [WIDTH-1:0]       rf_data,
    input  logic [NSRC-1:0]        src_valid,
    input  logic [NSRC*ADDR_W-1:0] src_addr,
    input  logic [NSRC*WIDTH-1:0]  src_data,
    input  logic [NSRC-1:0]        src_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   hazard,
    output logic [HCNT_W-1:0]      hazard_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic              wb_wr_en;
    logic              buf_hit;
    logic [WIDTH-1:0]  buf_data;
    logic              found;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_ready;
    logic              capture;
    logic              vld_p1;
    logic [WIDTH-1:0]  data_p1;

    assign wb_wr_en = src_valid[NSRC-1] &&
                      (src_addr[(NSRC-1)*ADDR_W +: ADDR_W] != ZERO_ADDR);

    bypass_wbuf #(
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_wbuf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wb_wr_en),
        .wr_addr(src_addr[(NSRC-1)*ADDR_W +: ADDR_W]),
        .wr_data(src_data[(NSRC-1)*WIDTH +: WIDTH]),
        .rd_addr(req_addr),
        .hit    (buf_hit),
        .rd_data(buf_data)
    );

    // In-flight sources beat the buffer, so the buffer only supplies older data.
    always_comb begin
        found     = 1'b0;
        sel_data  = rf_data;
        sel_ready = 1'b1;
        if (req_addr == ZERO_ADDR) begin
            sel_data = '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (!found && src_valid[i] &&
                    src_addr[i*ADDR_W +: ADDR_W] == req_addr) begin
                    found     = 1'b1;
                    sel_data  = src_data[i*WIDTH +: WIDTH];
                    sel_ready = src_ready[i];
                end
            end
            if (!found && buf_hit) begin
                sel_data = buf_data;
            end
        end
    end

    assign hazard  = req_valid && !sel_ready;
    assign capture = req_valid && !hazard;

    // Stage p1: operand register toward execute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= capture;
            if (capture) begin
                data_p1 <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hazard_cnt <= '0;
        end else if (hazard) begin
            hazard_cnt <= sat_inc(hazard_cnt);
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;

endmodule

// File: tb/tb_operand_bypass.sv
// Directed bench for operand_bypass with a queue-based reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_operand_bypass;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NS = 3;
    localparam int DP = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall, flush, req_valid;
    logic [AW-1:0]    req_addr;
    logic [W-1:0]     rf_data;
    logic [NS-1:0]    src_valid, src_ready;
    logic [NS*AW-1:0] src_addr;
    logic [NS*W-1:0]  src_data;
    logic             out_valid, hazard;
    logic [W-1:0]     out_data;
    logic [15:0]      hazard_cnt;

    int total = 0;
    int bad   = 0;

    operand_bypass #(.WIDTH(W), .ADDR_W(AW), .NSRC(NS), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .req_valid(req_valid), .req_addr(req_addr), .rf_data(rf_data),
        .src_valid(src_valid), .src_addr(src_addr), .src_data(src_data),
        .src_ready(src_ready), .out_valid(out_valid), .out_data(out_data),
        .hazard(hazard), .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: committed writes kept as a list of the last DP nonzero WB writes.
    logic [AW-1:0] q_addr [$];
    logic [W-1:0]  q_data [$];
    logic          m_valid;
    logic [W-1:0]  m_data;
    int            m_cnt;

    function automatic void msel(output logic [W-1:0] d, output logic rdy);
        d   = rf_data;
        rdy = 1'b1;
        if (req_addr == 0) begin
            d = '0;
            return;
        end
        for (int i = 0; i < NS; i++) begin
            if (src_valid[i] && src_addr[i*AW +: AW] == req_addr) begin
                d   = src_data[i*W +: W];
                rdy = src_ready[i];
                return;
            end
        end
        for (int k = q_addr.size() - 1; k >= 0; k--) begin
            if (q_addr[k] == req_addr) begin
                d = q_data[k];
                return;
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [W-1:0] d;
        logic         r;
        logic         hz;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_cnt   = 0;
            q_addr.delete();
            q_data.delete();
        end else begin
            msel(d, r);
            hz = req_valid && !r;
            if (hz && m_cnt < 16'hFFFF) m_cnt++;
            if (flush) m_valid = 1'b0;
            else if (!stall) begin
                m_valid = req_valid && !hz;
                if (m_valid) m_data = d;
            end
            if (src_valid[NS-1] && src_addr[(NS-1)*AW +: AW] != 0) begin
                q_addr.push_back(src_addr[(NS-1)*AW +: AW]);
                q_data.push_back(src_data[(NS-1)*W +: W]);
                if (q_addr.size() > DP) begin
                    q_addr.delete(0);
                    q_data.delete(0);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] d;
        logic         r;
        msel(d, r);
        chk("m_hazard", {31'd0, hazard}, {31'd0, req_valid && !r});
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) chk("m_out_data", out_data, m_data);
        chk("m_hazard_cnt", {16'd0, hazard_cnt}, m_cnt);
    end

    task automatic set_src(input int i, input logic v, input logic [AW-1:0] a,
                           input logic [W-1:0] d, input logic r);
        src_valid[i]        = v;
        src_addr[i*AW +: AW] = a;
        src_data[i*W +: W]   = d;
        src_ready[i]        = r;
    endtask

    task automatic clear_src();
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
        src_ready = '1;
    endtask

    task automatic req(input logic v, input logic [AW-1:0] a, input logic [W-1:0] rf);
        req_valid = v;
        req_addr  = a;
        rf_data   = rf;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        req(1'b0, '0, '0);
        clear_src();
        repeat (2) tick();
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_cnt", {16'd0, hazard_cnt}, 32'd0);
        rst = 1'b0;

        req(1'b1, 5'd3, 32'h11);
        tick();
        chk("first_rf", out_data, 32'h11);
        chk("first_valid", {31'd0, out_valid}, 32'd1);

        set_src(0, 1'b1, 5'd5, 32'hAAAA, 1'b1);
        set_src(2, 1'b1, 5'd5, 32'hCCCC, 1'b1);
        req(1'b1, 5'd5, 32'h0);
        tick();
        chk("prio_src0", out_data, 32'hAAAA);
        set_src(0, 1'b0, 5'd0, 32'h0, 1'b1);
        tick();
        chk("prio_src2", out_data, 32'hCCCC);

        clear_src();
        set_src(0, 1'b1, 5'd7, 32'h0, 1'b0);
        req(1'b1, 5'd7, 32'h0);
        #1 chk("loaduse_hazard", {31'd0, hazard}, 32'd1);
        repeat (3) tick();
        chk("loaduse_valid", {31'd0, out_valid}, 32'd0);
        chk("loaduse_cnt", {16'd0, hazard_cnt}, 32'd3);
        set_src(0, 1'b1, 5'd7, 32'h1234, 1'b1);
        tick();
        chk("loaduse_data", out_data, 32'h1234);
        chk("loaduse_cnt_hold", {16'd0, hazard_cnt}, 32'd3);

        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", out_data, 32'd0);
        chk("midrst_cnt", {16'd0, hazard_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        clear_src();
        req(1'b0, '0, '0);

        set_src(2, 1'b1, 5'd4, 32'd1, 1'b1);
        tick();
        set_src(2, 1'b1, 5'd4, 32'd2, 1'b1);
        tick();
        set_src(2, 1'b1, 5'd9, 32'd3, 1'b1);
        tick();
        clear_src();
        req(1'b1, 5'd4, 32'd0);
        tick();
        chk("wbuf_newest", out_data, 32'd2);
        req(1'b0, '0, '0);
        set_src(2, 1'b1, 5'd6, 32'd7, 1'b1);
        tick();
        clear_src();
        req(1'b1, 5'd4, 32'hDEAD);
        tick();
        chk("wbuf_evict", out_data, 32'hDEAD);

        set_src(0, 1'b1, 5'd0, 32'hFFFF, 1'b0);
        set_src(2, 1'b1, 5'd0, 32'h5A5A, 1'b1);
        req(1'b1, 5'd0, 32'h77);
        #1 chk("zero_hazard", {31'd0, hazard}, 32'd0);
        tick();
        chk("zero_data", out_data, 32'd0);
        clear_src();

        req(1'b1, 5'd8, 32'h55);
        tick();
        chk("stall_cap", out_data, 32'h55);
        stall = 1'b1;
        req(1'b1, 5'd9, 32'h66);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_hold", out_data, 32'h55);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        flush = 1'b1;
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        stall = 1'b0;
        req(1'b0, '0, '0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
